serial_mem_bridge: RTL

Memory-side stage directly downstream of the single-cycle datapath. It consumes the core's load/store request (address, store data, read_enable, write_enable) and serialises it as a byte-wide frame over an 8-bit transmit/receive pin interface. It returns load data and a one-cycle mem_done pulse, which releases the core's stalled PC.

---
 rtl/rv32i_defs.sv | 19 +
 rtl/serial_mem_bridge_byte_serializer.sv | 40 ++++
 rtl/serial_mem_bridge.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rv32i_defs.sv
// Shared definitions for the core's memory-side serial bridge.
package rv32i_defs;

  localparam int unsigned OperandSize = 32;

  // Frame command bytes, sent first in every frame.
  localparam logic [7:0] CmdRead  = 8'h01;
  localparam logic [7:0] CmdWrite = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StRdata,
    StDone
  } bridge_state_e;

endpackage

// File: rtl/serial_mem_bridge_byte_serializer.sv
// Steps through the low nbytes of a word, LSB first, one byte per valid/ready transfer.
module byte_serializer
  import rv32i_defs::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OperandSize-1:0] word,
  input  logic [2:0]             nbytes,
  input  logic                   load,
  input  logic                   tx_ready,
  output logic [7:0]             data,
  output logic                   valid,
  output logic                   last
);

  logic [1:0] cnt_q;
  logic       busy_q;

  // Word is held stable by the owner for the whole phase, so data only moves on a transfer.
  assign valid = busy_q;
  assign data  = busy_q ? word[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign last  = busy_q & tx_ready & ({1'b0, cnt_q} == (nbytes - 3'd1));

  // Byte index and busy flag; a load in the same cycle as the last transfer chains phases.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= 2'd0;
      busy_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= 2'd0;
      busy_q <= 1'b1;
    end else if (last) begin
      cnt_q  <= 2'd0;
      busy_q <= 1'b0;
    end else if (busy_q && tx_ready) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/serial_mem_bridge.sv
// Serialises datapath load/store requests into byte frames and returns load data.
module serial_mem_bridge
  import rv32i_defs::*;
#(
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned RX_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OperandSize-1:0] addr,
  input  logic [OperandSize-1:0] wdata,
  input  logic                   read_enable,
  input  logic                   write_enable,
  output logic [OperandSize-1:0] read_data,
  output logic                   mem_done,
  output logic                   timeout,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid
);

  localparam logic [2:0]  AddrBytesW  = 3'(ADDR_BYTES);
  localparam logic [15:0] RxTimeoutM1 = 16'(RX_TIMEOUT - 1);

  bridge_state_e          state_q;
  logic                   is_write_q;
  logic [OperandSize-1:0] addr_q;
  logic [OperandSize-1:0] wdata_q;
  logic [23:0]            rbuf_q;
  logic [1:0]             rcnt_q;
  logic [15:0]            wait_q;

  logic                   ser_load;
  logic                   ser_last;
  logic                   ser_valid;
  logic [7:0]             ser_data;
  logic [OperandSize-1:0] ser_word;
  logic [2:0]             ser_nbytes;

  assign ser_word   = (state_q == StWdata) ? wdata_q : addr_q;
  assign ser_nbytes = (state_q == StAddr) ? AddrBytesW : 3'd4;
  // Address phase starts when the command byte goes out; data phase chains off the last address byte.
  assign ser_load   = ((state_q == StCmd) && tx_ready) ||
                      ((state_q == StAddr) && ser_last && is_write_q);

  byte_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .word     (ser_word),
    .nbytes   (ser_nbytes),
    .load     (ser_load),
    .tx_ready (tx_ready),
    .data     (ser_data),
    .valid    (ser_valid),
    .last     (ser_last)
  );

  // Outbound byte depends only on registered state, never on tx_ready.
  assign tx_valid = (state_q == StCmd) | ser_valid;
  assign tx_data  = (state_q == StCmd) ? (is_write_q ? CmdWrite : CmdRead) : ser_data;

  // Frame sequencing, load collection with timeout, and the completion pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      rcnt_q     <= 2'd0;
      wait_q     <= 16'd0;
      read_data  <= '0;
      mem_done   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      timeout  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (read_enable || write_enable) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            is_write_q <= write_enable;
            state_q    <= StCmd;
          end
        end
        StCmd: begin
          if (tx_ready) state_q <= StAddr;
        end
        StAddr: begin
          if (ser_last) begin
            state_q <= is_write_q ? StWdata : StRdata;
            rcnt_q  <= 2'd0;
            wait_q  <= 16'd0;
          end
        end
        StWdata: begin
          if (ser_last) begin
            state_q  <= StDone;
            mem_done <= 1'b1;
          end
        end
        StRdata: begin
          if (rx_valid) begin
            wait_q <= 16'd0;
            rcnt_q <= rcnt_q + 2'd1;
            if (rcnt_q == 2'd3) begin
              read_data <= {rx_data, rbuf_q};
              state_q   <= StDone;
              mem_done  <= 1'b1;
            end else begin
              rbuf_q[{rcnt_q, 3'b000} +: 8] <= rx_data;
            end
          end else if (wait_q == RxTimeoutM1) begin
            read_data <= 32'hFFFF_FFFF;
            state_q   <= StDone;
            mem_done  <= 1'b1;
            timeout   <= 1'b1;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
